gray_sobel_edge: RTL and testbench



---
 rtl/sobel_pkg.sv | 39 +++
 rtl/gray_line_buffer.sv | 36 +++
 rtl/gray_sobel_edge.sv | 177 +++++++++++++++++
 tb/tb_gray_sobel_edge.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants, types and helpers for the gray_sobel_edge pipeline.
package sobel_pkg;

  localparam int PIX_W         = 8;
  localparam int COORD_W       = 16;
  localparam int GRAD_W        = 11;
  localparam int MAG_W         = 11;
  localparam int SOBEL_LATENCY = 4;

  // Sobel kernel weights: outer taps weigh 1, the centre tap of a column/row weighs 2.
  localparam int K_SIDE = 1;
  localparam int K_MID  = 2;

  // Sideband that travels alongside each pixel through the pipeline.
  typedef struct packed {
    logic               dval;
    logic               in_range;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pix_tag_t;

  // 3x3 window indexed [row][col], row 0 = oldest line, col 2 = newest pixel.
  typedef logic [2:0][2:0][PIX_W-1:0] window_t;

  // One side of a Sobel kernel: a + 2b + c.
  function automatic int weighted_sum(input logic [PIX_W-1:0] a,
                                      input logic [PIX_W-1:0] b,
                                      input logic [PIX_W-1:0] c);
    return K_SIDE * int'(a) + K_MID * int'(b) + K_SIDE * int'(c);
  endfunction

  // Magnitude of a signed gradient; |g| never exceeds 1020, so it fits in GRAD_W-1 bits.
  function automatic logic [GRAD_W-2:0] grad_abs(input logic signed [GRAD_W-1:0] g);
    logic signed [GRAD_W-1:0] m;
    m = (g < 0) ? -g : g;
    return (GRAD_W-1)'(m);
  endfunction

endpackage

// File: rtl/gray_line_buffer.sv
// One line of gray pixels: simple dual-port RAM, registered read,
// old data returned when reading and writing the same address in one clock.
module gray_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
)(
  input  logic              iCLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rd_data_q;

  // RAM-style write and registered read; both are non-blocking so a same-address
  // read sees the contents from before this clock's write. The read register is
  // left without reset so the pair maps onto a block RAM; the pipeline only
  // consumes it after a valid read has loaded it.
  always_ff @(posedge iCLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gray_sobel_edge.sv
// Streaming 3x3 Sobel edge detector behind the RGB-to-gray converter.
// Fixed 4-clock latency, no backpressure, two line buffers (lb0 = previous
// line, lb1 = line before that).
// Optional build macro SOBEL_THRESH_EN: binarise the magnitude against iThresh
// instead of outputting the saturated magnitude.
module gray_sobel_edge
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = SOBEL_LATENCY
)(
  input  logic               iCLK,
  input  logic               iReset_n,
  input  logic [PIX_W-1:0]   iGray,
  input  logic               iDval,
  input  logic [COORD_W-1:0] iX_Cont,
  input  logic [COORD_W-1:0] iY_Cont,
  input  logic [PIX_W-1:0]   iThresh,
  output logic [PIX_W-1:0]   oEdge,
  output logic [COORD_W-1:0] oX_Cont,
  output logic [COORD_W-1:0] oY_Cont,
  output logic               oDval
);

  localparam int unused_latency = LATENCY;

  logic               in_range;
  logic [ADDR_W-1:0]  addr;
  logic [PIX_W-1:0]   lb0_rd;
  logic [PIX_W-1:0]   lb1_rd;

  pix_tag_t           s0_tag_d, s0_tag_q;
  logic [PIX_W-1:0]   s0_gray_d, s0_gray_q;
  logic [ADDR_W-1:0]  s0_addr_d, s0_addr_q;

  pix_tag_t           s1_tag_d, s1_tag_q;
  window_t            win_d, win_q;

  pix_tag_t           s2_tag_d, s2_tag_q;
  logic signed [GRAD_W-1:0] gx, gy;
  logic [GRAD_W-2:0]  abs_gx_d, abs_gx_q;
  logic [GRAD_W-2:0]  abs_gy_d, abs_gy_q;

  logic [MAG_W-1:0]   mag;
  logic               keep;
  logic [PIX_W-1:0]   edge_val;
  logic [PIX_W-1:0]   edge_d, edge_q;
  logic               dval_d, dval_q;
  logic [COORD_W-1:0] x_d, x_q;
  logic [COORD_W-1:0] y_d, y_q;

  // Stage 0: decide whether this pixel touches the line buffers and capture its sideband.
  always_comb begin
    in_range           = iDval && (iX_Cont < COORD_W'(IMG_WIDTH));
    addr               = iX_Cont[ADDR_W-1:0];
    s0_tag_d.dval      = iDval;
    s0_tag_d.in_range  = in_range;
    s0_tag_d.x         = iX_Cont;
    s0_tag_d.y         = iY_Cont;
    s0_gray_d          = iGray;
    s0_addr_d          = addr;
  end

  gray_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_lb0 (
    .iCLK    (iCLK),
    .wr_en   (in_range),
    .wr_addr (addr),
    .wr_data (iGray),
    .rd_en   (in_range),
    .rd_addr (addr),
    .rd_data (lb0_rd)
  );

  // lb1 receives the line that lb0 is evicting; the old lb0 word only appears
  // one clock after the read, so the write uses the stage-0 address.
  gray_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_lb1 (
    .iCLK    (iCLK),
    .wr_en   (s0_tag_q.in_range),
    .wr_addr (s0_addr_q),
    .wr_data (lb0_rd),
    .rd_en   (in_range),
    .rd_addr (addr),
    .rd_data (lb1_rd)
  );

  // Stage 1: slide the window one column left on in-range valid pixels only.
  always_comb begin
    win_d    = win_q;
    s1_tag_d = s0_tag_q;
    if (s0_tag_q.in_range) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = s0_gray_q;
    end
  end

  // Stage 2: horizontal and vertical gradients, kept as magnitudes.
  always_comb begin
    gx = GRAD_W'(weighted_sum(win_q[0][2], win_q[1][2], win_q[2][2])
               - weighted_sum(win_q[0][0], win_q[1][0], win_q[2][0]));
    gy = GRAD_W'(weighted_sum(win_q[2][0], win_q[2][1], win_q[2][2])
               - weighted_sum(win_q[0][0], win_q[0][1], win_q[0][2]));
    abs_gx_d = grad_abs(gx);
    abs_gy_d = grad_abs(gy);
    s2_tag_d = s1_tag_q;
  end

  // Stage 3: combine gradients, map to 8 bits and blank borders, gaps and out-of-range pixels.
  always_comb begin
    mag  = MAG_W'({1'b0, abs_gx_q}) + MAG_W'({1'b0, abs_gy_q});
    keep = s2_tag_q.dval && s2_tag_q.in_range &&
           (s2_tag_q.x >= COORD_W'(2)) && (s2_tag_q.y >= COORD_W'(2));
`ifdef SOBEL_THRESH_EN
    edge_val = (mag >= MAG_W'(iThresh)) ? '1 : '0;
`else
    edge_val = (mag > MAG_W'(255)) ? '1 : mag[PIX_W-1:0];
`endif
    edge_d = keep ? edge_val : '0;
    dval_d = s2_tag_q.dval;
    x_d    = s2_tag_q.x;
    y_d    = s2_tag_q.y;
  end

`ifndef SOBEL_THRESH_EN
  logic unused_thresh;
  assign unused_thresh = ^iThresh;
`endif

  // All pipeline, window and output registers clear asynchronously on reset.
  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      s0_tag_q  <= '0;
      s0_gray_q <= '0;
      s0_addr_q <= '0;
      s1_tag_q  <= '0;
      win_q     <= '0;
      s2_tag_q  <= '0;
      abs_gx_q  <= '0;
      abs_gy_q  <= '0;
      edge_q    <= '0;
      dval_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      s0_tag_q  <= s0_tag_d;
      s0_gray_q <= s0_gray_d;
      s0_addr_q <= s0_addr_d;
      s1_tag_q  <= s1_tag_d;
      win_q     <= win_d;
      s2_tag_q  <= s2_tag_d;
      abs_gx_q  <= abs_gx_d;
      abs_gy_q  <= abs_gy_d;
      edge_q    <= edge_d;
      dval_q    <= dval_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign oEdge   = edge_q;
  assign oDval   = dval_q;
  assign oX_Cont = x_q;
  assign oY_Cont = y_q;

endmodule

// File: tb/tb_gray_sobel_edge.sv
// Scoreboard bench for gray_sobel_edge on a 16x8 image. Expected outputs come
// from a frame-array reference model and are queued when each pixel is driven;
// the DUT output seen four clocks later is popped and compared.
module tb_gray_sobel_edge;

  localparam int W = 16;
  localparam int H = 8;
`ifdef SOBEL_THRESH_EN
  localparam logic [7:0] RAMP_EDGE = 8'd255;
`else
  localparam logic [7:0] RAMP_EDGE = 8'd80;
`endif

  logic        iCLK = 1'b0;
  logic        iReset_n = 1'b1;
  logic [7:0]  iGray = '0;
  logic        iDval = 1'b0;
  logic [15:0] iX_Cont = '0;
  logic [15:0] iY_Cont = '0;
  logic [7:0]  iThresh = 8'd60;
  logic [7:0]  oEdge;
  logic [15:0] oX_Cont;
  logic [15:0] oY_Cont;
  logic        oDval;

  typedef struct packed {
    logic        dval;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  edge_v;
  } out_t;

  out_t       exp_q[$];
  out_t       obs;
  out_t       exp_o;
  bit         have_exp;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] img [H][W];
  logic [7:0] thresh_model = 8'd60;

  gray_sobel_edge #(
    .IMG_WIDTH (W),
    .ADDR_W    (4),
    .LATENCY   (4)
  ) dut (
    .iCLK     (iCLK),
    .iReset_n (iReset_n),
    .iGray    (iGray),
    .iDval    (iDval),
    .iX_Cont  (iX_Cont),
    .iY_Cont  (iY_Cont),
    .iThresh  (iThresh),
    .oEdge    (oEdge),
    .oX_Cont  (oX_Cont),
    .oY_Cont  (oY_Cont),
    .oDval    (oDval)
  );

  always #5 iCLK = ~iCLK;

  // Reference: Sobel over the stored frame, centred one pixel up-left of (x, y).
  function automatic logic [7:0] ref_edge(input logic dval, input int x, input int y);
    int gx, gy, mag;
    if (!dval || x >= W || x < 2 || y < 2) return 8'd0;
    gx = (int'(img[y-2][x]) + 2*int'(img[y-1][x]) + int'(img[y][x]))
       - (int'(img[y-2][x-2]) + 2*int'(img[y-1][x-2]) + int'(img[y][x-2]));
    gy = (int'(img[y][x-2]) + 2*int'(img[y][x-1]) + int'(img[y][x]))
       - (int'(img[y-2][x-2]) + 2*int'(img[y-2][x-1]) + int'(img[y-2][x]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    mag = gx + gy;
`ifdef SOBEL_THRESH_EN
    return (mag >= int'(thresh_model)) ? 8'd255 : 8'd0;
`else
    return (mag > 255) ? 8'd255 : 8'(mag);
`endif
  endfunction

  // Image patterns: 0 flat, 1 vertical step at x=8, 2 vertical ramp 10*y.
  function automatic logic [7:0] pix_val(input int mode, input int x, input int y);
    case (mode)
      0:       return 8'd100;
      1:       return (x < 8) ? 8'd0 : 8'd200;
      default: return 8'(10 * y);
    endcase
  endfunction

  // Sample the DUT at the falling edge, pop the expectation due now, then drive
  // the next pixel and queue its expected output.
  task automatic applyStimulus(input logic [7:0] gray, input logic dval, input int x, input int y);
    @(negedge iCLK);
    obs = '{dval: oDval, x: oX_Cont, y: oY_Cont, edge_v: oEdge};
    have_exp = (exp_q.size() >= 4);
    if (have_exp) exp_o = exp_q.pop_front();
    iGray   = gray;
    iDval   = dval;
    iX_Cont = 16'(x);
    iY_Cont = 16'(y);
`ifndef SOBEL_THRESH_EN
    iThresh = 8'($urandom);
`endif
    if (dval && x < W && y < H) img[y][x] = gray;
    exp_q.push_back('{dval: dval, x: 16'(x), y: 16'(y), edge_v: ref_edge(dval, x, y)});
  endtask

  task automatic test_reset();
    #1 iReset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      checks++;
      if ({oDval, oX_Cont, oY_Cont, oEdge} !== 41'd0) begin
        errors++;
        $display("[TB] FAIL reset: got dval=%0b x=%0d y=%0d edge=%0d, expected all 0",
                 oDval, oX_Cont, oY_Cont, oEdge);
      end
    end
    iReset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_flat();
    int dv_count = 0;
    for (int c = 0; c < H*W + 4; c++) begin
      if (c < H*W) applyStimulus(pix_val(0, c % W, c / W), 1'b1, c % W, c / W);
      else         applyStimulus(8'd0, 1'b0, 0, 0);
      if (have_exp) begin
        checks++;
        if (obs.dval) dv_count++;
        if (obs !== exp_o) begin
          errors++;
          $display("[TB] FAIL flat c=%0d: got dval=%0b x=%0d y=%0d edge=%0d, expected dval=%0b x=%0d y=%0d edge=%0d",
                   c, obs.dval, obs.x, obs.y, obs.edge_v, exp_o.dval, exp_o.x, exp_o.y, exp_o.edge_v);
        end
      end
    end
    checks++;
    if (dv_count != H*W) begin
      errors++;
      $display("[TB] FAIL flat_dval_count: got %0d, expected %0d", dv_count, H*W);
    end
  endtask

  task automatic test_vstep();
    int hits = 0;
    for (int c = 0; c < H*W + 4; c++) begin
      if (c < H*W) applyStimulus(pix_val(1, c % W, c / W), 1'b1, c % W, c / W);
      else         applyStimulus(8'd0, 1'b0, 0, 0);
      if (have_exp) begin
        checks++;
        if (obs.dval && obs.edge_v == 8'd255) hits++;
        if (obs !== exp_o) begin
          errors++;
          $display("[TB] FAIL vstep c=%0d: got dval=%0b x=%0d y=%0d edge=%0d, expected dval=%0b x=%0d y=%0d edge=%0d",
                   c, obs.dval, obs.x, obs.y, obs.edge_v, exp_o.dval, exp_o.x, exp_o.y, exp_o.edge_v);
        end
      end
    end
    checks++;
    if (hits != 12) begin
      errors++;
      $display("[TB] FAIL vstep_edge_count: got %0d, expected 12", hits);
    end
  endtask

  task automatic test_ramp();
    int hits = 0;
    for (int c = 0; c < H*W + 4; c++) begin
      if (c < H*W) applyStimulus(pix_val(2, c % W, c / W), 1'b1, c % W, c / W);
      else         applyStimulus(8'd0, 1'b0, 0, 0);
      if (have_exp) begin
        checks++;
        if (obs.dval && obs.edge_v == RAMP_EDGE) hits++;
        if (obs !== exp_o) begin
          errors++;
          $display("[TB] FAIL ramp c=%0d: got dval=%0b x=%0d y=%0d edge=%0d, expected dval=%0b x=%0d y=%0d edge=%0d",
                   c, obs.dval, obs.x, obs.y, obs.edge_v, exp_o.dval, exp_o.x, exp_o.y, exp_o.edge_v);
        end
      end
    end
    checks++;
    if (hits != 84) begin
      errors++;
      $display("[TB] FAIL ramp_edge_count: got %0d, expected 84", hits);
    end
  endtask

  task automatic test_gaps();
    int hits = 0;
    int dv_count = 0;
    for (int c = 0; c < 2*H*W + 4; c++) begin
      if (c < 2*H*W) begin
        if (c % 2 == 0) applyStimulus(pix_val(1, (c/2) % W, (c/2) / W), 1'b1, (c/2) % W, (c/2) / W);
        else            applyStimulus(8'($urandom), 1'b0, (c/2) % W, (c/2) / W);
      end else begin
        applyStimulus(8'd0, 1'b0, 0, 0);
      end
      if (have_exp) begin
        checks++;
        if (obs.dval) dv_count++;
        if (obs.dval && obs.edge_v == 8'd255) hits++;
        if (obs !== exp_o) begin
          errors++;
          $display("[TB] FAIL gaps c=%0d: got dval=%0b x=%0d y=%0d edge=%0d, expected dval=%0b x=%0d y=%0d edge=%0d",
                   c, obs.dval, obs.x, obs.y, obs.edge_v, exp_o.dval, exp_o.x, exp_o.y, exp_o.edge_v);
        end
      end
    end
    checks++;
    if (dv_count != H*W || hits != 12) begin
      errors++;
      $display("[TB] FAIL gaps_counts: got dval=%0d edges=%0d, expected dval=%0d edges=12", dv_count, hits, H*W);
    end
  endtask

  task automatic test_out_of_range();
    int hits = 0;
    for (int c = 0; c < H*(W+2) + 4; c++) begin
      if (c < H*(W+2)) begin
        if (c % (W+2) < W) applyStimulus(pix_val(2, c % (W+2), c / (W+2)), 1'b1, c % (W+2), c / (W+2));
        else               applyStimulus(8'hFF, 1'b1, c % (W+2), c / (W+2));
      end else begin
        applyStimulus(8'd0, 1'b0, 0, 0);
      end
      if (have_exp) begin
        checks++;
        if (obs.dval && obs.edge_v == RAMP_EDGE) hits++;
        if (obs !== exp_o) begin
          errors++;
          $display("[TB] FAIL out_of_range c=%0d: got dval=%0b x=%0d y=%0d edge=%0d, expected dval=%0b x=%0d y=%0d edge=%0d",
                   c, obs.dval, obs.x, obs.y, obs.edge_v, exp_o.dval, exp_o.x, exp_o.y, exp_o.edge_v);
        end
      end
    end
    checks++;
    if (hits != 84) begin
      errors++;
      $display("[TB] FAIL out_of_range_edge_count: got %0d, expected 84", hits);
    end
  endtask

  task automatic test_reset_midframe();
    int hits = 0;
    for (int c = 0; c < 5*W + 8; c++) begin
      applyStimulus(pix_val(1, c % W, c / W), 1'b1, c % W, c / W);
      if (have_exp) begin
        checks++;
        if (obs !== exp_o) begin
          errors++;
          $display("[TB] FAIL pre_reset c=%0d: got dval=%0b x=%0d y=%0d edge=%0d, expected dval=%0b x=%0d y=%0d edge=%0d",
                   c, obs.dval, obs.x, obs.y, obs.edge_v, exp_o.dval, exp_o.x, exp_o.y, exp_o.edge_v);
        end
      end
    end
    #2;
    iReset_n = 1'b0;
    iDval    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) #1;
      else        @(negedge iCLK);
      checks++;
      if ({oDval, oX_Cont, oY_Cont, oEdge} !== 41'd0) begin
        errors++;
        $display("[TB] FAIL midframe_reset i=%0d: got dval=%0b x=%0d y=%0d edge=%0d, expected all 0",
                 i, oDval, oX_Cont, oY_Cont, oEdge);
      end
    end
    iReset_n = 1'b1;
    exp_q.delete();
    for (int c = 0; c < H*W + 4; c++) begin
      if (c < H*W) applyStimulus(pix_val(2, c % W, c / W), 1'b1, c % W, c / W);
      else         applyStimulus(8'd0, 1'b0, 0, 0);
      if (have_exp) begin
        checks++;
        if (obs.dval && obs.edge_v == RAMP_EDGE) hits++;
        if (obs !== exp_o) begin
          errors++;
          $display("[TB] FAIL post_reset c=%0d: got dval=%0b x=%0d y=%0d edge=%0d, expected dval=%0b x=%0d y=%0d edge=%0d",
                   c, obs.dval, obs.x, obs.y, obs.edge_v, exp_o.dval, exp_o.x, exp_o.y, exp_o.edge_v);
        end
      end
    end
    checks++;
    if (hits != 84) begin
      errors++;
      $display("[TB] FAIL post_reset_edge_count: got %0d, expected 84", hits);
    end
  endtask

`ifdef SOBEL_THRESH_EN
  task automatic test_thresh();
    int hits;
    for (int pass = 0; pass < 2; pass++) begin
      hits = 0;
      thresh_model = (pass == 0) ? 8'd128 : 8'd0;
      iThresh      = thresh_model;
      for (int c = 0; c < H*W + 4; c++) begin
        if (c < H*W) applyStimulus(pix_val((pass == 0) ? 1 : 0, c % W, c / W), 1'b1, c % W, c / W);
        else         applyStimulus(8'd0, 1'b0, 0, 0);
        if (have_exp) begin
          checks++;
          if (obs.dval && obs.edge_v == 8'd255) hits++;
          if (obs !== exp_o) begin
            errors++;
            $display("[TB] FAIL thresh p=%0d c=%0d: got dval=%0b x=%0d y=%0d edge=%0d, expected dval=%0b x=%0d y=%0d edge=%0d",
                     pass, c, obs.dval, obs.x, obs.y, obs.edge_v, exp_o.dval, exp_o.x, exp_o.y, exp_o.edge_v);
          end
        end
      end
      checks++;
      if (hits != ((pass == 0) ? 12 : 84)) begin
        errors++;
        $display("[TB] FAIL thresh_count p=%0d: got %0d, expected %0d", pass, hits, (pass == 0) ? 12 : 84);
      end
    end
  endtask
`endif

  // Run every scenario in order on one continuous stream, then report.
  initial begin
    $display("[TB] gray_sobel_edge bench start");
    test_reset();
    test_flat();
    test_vstep();
    test_ramp();
    test_gaps();
    test_out_of_range();
    test_reset_midframe();
`ifdef SOBEL_THRESH_EN
    test_thresh();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
